// File: rtl/mux_4to1_case.sv
`default_nettype none
// ============================================================================
// Module   : mux_4to1_case
// Purpose  : Registered 4-to-1 mux; optional comb tap via MUX4_COMB_OUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module mux_4to1_case #(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] in_mux_1,
  input  logic [DATA_W-1:0] in_mux_2,
  input  logic [DATA_W-1:0] in_mux_3,
  input  logic [DATA_W-1:0] in_mux_4,
  input  logic [1:0]        sel_mux,
`ifdef MUX4_COMB_OUT_EN
  output logic [DATA_W-1:0] out_mux_comb,
`endif
  output logic [DATA_W-1:0] out_mux,
  output logic              out_valid
);

  logic [DATA_W-1:0] mux_d;
  logic [DATA_W-1:0] mux_q;
  logic              valid_q;

  // Default arm drives zeros so an unknown select never leaks stale data.
  always_comb begin
    mux_d = '0;
    case (sel_mux)
      2'b00:   mux_d = in_mux_1;
      2'b01:   mux_d = in_mux_2;
      2'b10:   mux_d = in_mux_3;
      2'b11:   mux_d = in_mux_4;
      default: mux_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mux_q   <= '0;
      valid_q <= 1'b0;
    end else if (en) begin
      mux_q   <= mux_d;
      valid_q <= 1'b1;
    end
  end

  assign out_mux   = mux_q;
  assign out_valid = valid_q;

`ifdef MUX4_COMB_OUT_EN
  assign out_mux_comb = mux_d;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_4to1_case.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_4to1_case
// Purpose  : Scoreboard bench for 1-bit and 8-bit mux_4to1_case instances.
// Revision : 1.0  initial release
// ============================================================================
module tb_mux_4to1_case;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [1:0] sel = 2'b00;
  logic       a1 = 0, a2 = 0, a3 = 0, a4 = 0;
  logic [7:0] b1 = 0, b2 = 0, b3 = 0, b4 = 0;
  logic       out1, valid1;
  logic [7:0] out8;
  logic       valid8;
`ifdef MUX4_COMB_OUT_EN
  logic       comb1;
  logic [7:0] comb8;
`endif

  typedef struct {
    logic       e1;
    logic [7:0] e8;
    logic       ev;
  } exp_t;

  exp_t       sb[$];
  exp_t       x;
  logic       m1 = 0;
  logic [7:0] m8 = 0;
  logic       mv = 0;
  int         n_cmp = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  mux_4to1_case #(.DATA_W(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en),
    .in_mux_1(a1), .in_mux_2(a2), .in_mux_3(a3), .in_mux_4(a4),
    .sel_mux(sel),
`ifdef MUX4_COMB_OUT_EN
    .out_mux_comb(comb1),
`endif
    .out_mux(out1), .out_valid(valid1)
  );

  mux_4to1_case #(.DATA_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .en(en),
    .in_mux_1(b1), .in_mux_2(b2), .in_mux_3(b3), .in_mux_4(b4),
    .sel_mux(sel),
`ifdef MUX4_COMB_OUT_EN
    .out_mux_comb(comb8),
`endif
    .out_mux(out8), .out_valid(valid8)
  );

  // Apply controls, push the expected post-edge state, then advance one edge.
  task automatic drive(input logic r, input logic e, input logic [1:0] s);
    exp_t t;
    rst = r; en = e; sel = s;
    if (r) begin
      m1 = 1'b0; m8 = 8'h00; mv = 1'b0;
    end else if (e) begin
      case (s)
        2'b00: begin m1 = a1; m8 = b1; end
        2'b01: begin m1 = a2; m8 = b2; end
        2'b10: begin m1 = a3; m8 = b3; end
        default: begin m1 = a4; m8 = b4; end
      endcase
      mv = 1'b1;
    end
    t.e1 = m1; t.e8 = m8; t.ev = mv;
    sb.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a1 = 1; a2 = 1; a3 = 1; a4 = 1;
    b1 = 8'hA5; b2 = 8'h3C; b3 = 8'hFF; b4 = 8'h11;
    for (int i = 0; i < 4; i++) begin
      if (i < 2) drive(1'b1, 1'b1, 2'(i));
      else       drive(1'b0, 1'b0, 2'(i));
      x = sb.pop_front();
      n_cmp++;
      if (out1 !== x.e1 || valid1 !== x.ev || out8 !== x.e8 || valid8 !== x.ev) begin
        n_fail++;
        $display("FAIL reset[%0d]: got out1=%b v1=%b out8=%h v8=%b, want out=%b/%h v=%b",
                 i, out1, valid1, out8, valid8, x.e1, x.e8, x.ev);
      end
    end
  endtask

  task automatic test_select_sweep();
    a1 = 1; a2 = 0; a3 = 0; a4 = 1;
    b1 = 8'h12; b2 = 8'h34; b3 = 8'h56; b4 = 8'h78;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 2'(i));
      x = sb.pop_front();
      n_cmp++;
      if (out1 !== x.e1 || valid1 !== x.ev || out8 !== x.e8 || valid8 !== x.ev) begin
        n_fail++;
        $display("FAIL sweep sel=%0d: got out1=%b v1=%b out8=%h v8=%b, want out=%b/%h v=%b",
                 i, out1, valid1, out8, valid8, x.e1, x.e8, x.ev);
      end
    end
  endtask

  task automatic test_hold();
    a1 = 1; a2 = 0;
    b1 = 8'hC3; b2 = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive(1'b0, 1'b1, 2'b00);
      else if (i < 3) begin
        a1 = 0; b1 = 8'h00;
        drive(1'b0, 1'b0, 2'b01);
      end else drive(1'b0, 1'b1, 2'b01);
      x = sb.pop_front();
      n_cmp++;
      if (out1 !== x.e1 || valid1 !== x.ev || out8 !== x.e8 || valid8 !== x.ev) begin
        n_fail++;
        $display("FAIL hold[%0d]: got out1=%b v1=%b out8=%h v8=%b, want out=%b/%h v=%b",
                 i, out1, valid1, out8, valid8, x.e1, x.e8, x.ev);
      end
    end
  endtask

  task automatic test_midstream_reset();
    a4 = 1; b4 = 8'h9E;
    for (int i = 0; i < 4; i++) begin
      if (i == 1)      drive(1'b1, 1'b1, 2'b11);
      else if (i == 2) drive(1'b0, 1'b0, 2'b11);
      else             drive(1'b0, 1'b1, 2'b11);
      x = sb.pop_front();
      n_cmp++;
      if (out1 !== x.e1 || valid1 !== x.ev || out8 !== x.e8 || valid8 !== x.ev) begin
        n_fail++;
        $display("FAIL midrst[%0d]: got out1=%b v1=%b out8=%h v8=%b, want out=%b/%h v=%b",
                 i, out1, valid1, out8, valid8, x.e1, x.e8, x.ev);
      end
    end
  endtask

  task automatic test_wide_back_to_back();
    a1 = 0; a2 = 1; a3 = 1; a4 = 0;
    b1 = 8'hA5; b2 = 8'h3C; b3 = 8'hFF; b4 = 8'h00;
    for (int i = 0; i < 6; i++) begin
      // Select and data change together on the last two cycles.
      if (i == 4) begin b2 = 8'h81; a2 = 0; end
      if (i == 5) begin b1 = 8'h7E; a1 = 1; end
      case (i)
        0: drive(1'b0, 1'b1, 2'b10);
        1: drive(1'b0, 1'b1, 2'b11);
        2: drive(1'b0, 1'b1, 2'b10);
        3: drive(1'b0, 1'b1, 2'b00);
        4: drive(1'b0, 1'b1, 2'b01);
        default: drive(1'b0, 1'b1, 2'b00);
      endcase
      x = sb.pop_front();
      n_cmp++;
      if (out1 !== x.e1 || valid1 !== x.ev || out8 !== x.e8 || valid8 !== x.ev) begin
        n_fail++;
        $display("FAIL wide[%0d]: got out1=%b v1=%b out8=%h v8=%b, want out=%b/%h v=%b",
                 i, out1, valid1, out8, valid8, x.e1, x.e8, x.ev);
      end
    end
  endtask

`ifdef MUX4_COMB_OUT_EN
  task automatic test_comb_out();
    a1 = 1; a2 = 0; a3 = 0; a4 = 1;
    b1 = 8'hA5; b2 = 8'h3C; b3 = 8'hFF; b4 = 8'h00;
    drive(1'b0, 1'b1, 2'b00);
    x = sb.pop_front();
    sel = 2'b11;
    #1;
    n_cmp++;
    if (comb1 !== 1'b1 || comb8 !== 8'h00 || out8 !== x.e8 || out1 !== x.e1) begin
      n_fail++;
      $display("FAIL comb_between_edges: got comb1=%b comb8=%h out1=%b out8=%h, want 1/00/%b/%h",
               comb1, comb8, out1, out8, x.e1, x.e8);
    end
    drive(1'b0, 1'b1, 2'b11);
    x = sb.pop_front();
    n_cmp++;
    if (out1 !== x.e1 || out8 !== x.e8 || comb8 !== 8'h00) begin
      n_fail++;
      $display("FAIL comb_after_edge: got out1=%b out8=%h comb8=%h, want %b/%h/00",
               out1, out8, comb8, x.e1, x.e8);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_select_sweep();
    test_hold();
    test_midstream_reset();
    test_wide_back_to_back();
`ifdef MUX4_COMB_OUT_EN
    test_comb_out();
`endif
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
